refresh_sched: RTL and testbench

REFRESH_SCHED -- requirements
Module: refresh_sched

---
 rtl/gc_ctrl_pkg.sv | 24 ++
 rtl/ref_timer.sv | 29 ++
 rtl/refresh_sched.sv | 98 +++++++++
 tb/tb_refresh_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_ctrl_pkg.sv
// Shared definitions for the refresh scheduler: refresh FSM encoding, default
// row-address width and the fixed READ->WRITE->DONE->IDLE walk.
package gc_ctrl_pkg;

  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ref_state_e;

  // Busy states each last one cycle; IDLE leaves only when a launch is granted.
  function automatic ref_state_e ref_next_state(input ref_state_e cur, input logic launch);
    case (cur)
      ST_IDLE:  ref_next_state = launch ? ST_READ : ST_IDLE;
      ST_READ:  ref_next_state = ST_WRITE;
      ST_WRITE: ref_next_state = ST_DONE;
      default:  ref_next_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ref_timer.sv
// Free-running refresh interval down-counter; flags zero for one cycle,
// then reloads PERIOD-1.
module ref_timer #(
  parameter int PERIOD = 64
) (
  input  logic clk,
  input  logic rst,
  output logic o_zero
);

  localparam int              CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/refresh_sched.sv
// Refresh scheduler: launches a READ/WRITE/DONE row refresh every REF_PERIOD
// cycles, yielding to user traffic for at most MAX_DEFER cycles.
module refresh_sched
  import gc_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int REF_PERIOD = 64,
  parameter int MAX_DEFER  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_gnt,
  output logic              rd_gnt,
  output logic [ADDR_W-1:0] ref_mem_addr,
  output logic              ref_rd_en,
  output logic              ref_wr_en,
  output logic              ref_done,
  output logic              ref_busy,
  output logic              urgent
);

  localparam int               DEF_W     = $clog2(MAX_DEFER + 1);
  localparam logic [DEF_W-1:0] DEF_LIMIT = DEF_W'(MAX_DEFER);

  ref_state_e        r_state;
  ref_state_e        w_state_nxt;
  logic              r_pending;
  logic [DEF_W-1:0]  r_defer_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic w_tmr_zero;
  logic w_user_req;
  logic w_want;
  logic w_urgent;
  logic w_launch;

  ref_timer #(
    .PERIOD (REF_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .o_zero (w_tmr_zero)
  );

  assign w_user_req = wr_req | rd_req;
  // A refresh is wanted on the expiry cycle itself, so deferral counts from there.
  assign w_want     = (r_state == ST_IDLE) & (w_tmr_zero | r_pending);
  assign w_urgent   = (r_state == ST_IDLE) & r_pending & (r_defer_cnt == DEF_LIMIT);
  assign w_launch   = w_want & (~w_user_req | w_urgent);

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = ref_next_state(r_state, w_launch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_defer_cnt <= '0;
      r_addr      <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Launch wins over a coincident expiry; pending is one bit, never a count.
      if (w_launch) begin
        r_pending <= 1'b0;
      end else if (w_tmr_zero) begin
        r_pending <= 1'b1;
      end

      if (w_launch) begin
        r_defer_cnt <= '0;
      end else if (w_want && w_user_req) begin
        r_defer_cnt <= r_defer_cnt + 1'b1;
      end

      if (r_state == ST_DONE) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign ref_mem_addr = r_addr;
  assign ref_busy     = (r_state != ST_IDLE);
  assign ref_rd_en    = (r_state == ST_READ);
  assign ref_wr_en    = (r_state == ST_WRITE);
  assign ref_done     = (r_state == ST_DONE);
  assign urgent       = w_urgent;

  // Write has priority; both grants are suppressed while refreshing or urgent.
  assign wr_gnt = wr_req & ~ref_busy & ~w_urgent;
  assign rd_gnt = rd_req & ~wr_req & ~ref_busy & ~w_urgent;

endmodule

// File: tb/tb_refresh_sched.sv
// Scoreboard bench for refresh_sched (REF_PERIOD=16, MAX_DEFER=4, ADDR_W=3):
// the driver queues per-cycle expectations, the monitor checks them on negedge.
module tb_refresh_sched;

  localparam int ADDR_W     = 3;
  localparam int REF_PERIOD = 16;
  localparam int MAX_DEFER  = 4;

  localparam int S_WR_GNT  = 0;
  localparam int S_RD_GNT  = 1;
  localparam int S_ADDR    = 2;
  localparam int S_RD_EN   = 3;
  localparam int S_WR_EN   = 4;
  localparam int S_DONE    = 5;
  localparam int S_BUSY    = 6;
  localparam int S_URGENT  = 7;
  localparam int S_DONECNT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_req = 1'b0;
  logic              rd_req = 1'b0;
  logic              wr_gnt;
  logic              rd_gnt;
  logic [ADDR_W-1:0] ref_mem_addr;
  logic              ref_rd_en;
  logic              ref_wr_en;
  logic              ref_done;
  logic              ref_busy;
  logic              urgent;

  refresh_sched #(
    .ADDR_W     (ADDR_W),
    .REF_PERIOD (REF_PERIOD),
    .MAX_DEFER  (MAX_DEFER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_gnt       (wr_gnt),
    .rd_gnt       (rd_gnt),
    .ref_mem_addr (ref_mem_addr),
    .ref_rd_en    (ref_rd_en),
    .ref_wr_en    (ref_wr_en),
    .ref_done     (ref_done),
    .ref_busy     (ref_busy),
    .urgent       (urgent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         rel;
    int         sig;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   gcyc     = 0;
  int   t0       = 0;
  int   done_cnt = 0;
  int   n_run    = 0;
  int   n_fail   = 0;

  always @(posedge clk) gcyc++;

  function automatic logic [7:0] get_sig(input int s);
    case (s)
      S_WR_GNT:  get_sig = {7'd0, wr_gnt};
      S_RD_GNT:  get_sig = {7'd0, rd_gnt};
      S_ADDR:    get_sig = {5'd0, ref_mem_addr};
      S_RD_EN:   get_sig = {7'd0, ref_rd_en};
      S_WR_EN:   get_sig = {7'd0, ref_wr_en};
      S_DONE:    get_sig = {7'd0, ref_done};
      S_BUSY:    get_sig = {7'd0, ref_busy};
      S_URGENT:  get_sig = {7'd0, urgent};
      default:   get_sig = done_cnt[7:0];
    endcase
  endfunction

  // Monitor: count done pulses, then retire every expectation due this cycle.
  always @(negedge clk) begin
    if (ref_done) done_cnt++;
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].cyc <= gcyc) begin
        n_run++;
        if (sb[i].cyc < gcyc) begin
          n_fail++;
          $display("FAIL %s cycle %0d: expectation not sampled in time, required %0d",
                   sb[i].tag, sb[i].rel, sb[i].val);
        end else if (get_sig(sb[i].sig) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cycle %0d: got %0d, required %0d",
                   sb[i].tag, sb[i].rel, get_sig(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic check(input int k, input int sig, input int v, input string tag);
    exp_t e;
    e.cyc = t0 + k;
    e.rel = k;
    e.sig = sig;
    e.val = v[7:0];
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    t0       = gcyc;
    done_cnt = 0;
  endtask

  task automatic go(input int k);
    while (gcyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() > 0 && b < 400) begin
      @(posedge clk);
      b++;
    end
    if (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    // Reset state and an undisturbed refresh of row 0.
    do_reset();
    check(0,  S_BUSY,   0, "rst_busy");
    check(0,  S_RD_EN,  0, "rst_rd_en");
    check(0,  S_WR_EN,  0, "rst_wr_en");
    check(0,  S_DONE,   0, "rst_done");
    check(0,  S_URGENT, 0, "rst_urgent");
    check(0,  S_ADDR,   0, "rst_addr");
    check(0,  S_WR_GNT, 0, "rst_wr_gnt");
    check(15, S_RD_EN,  0, "idle_pre_read");
    check(16, S_RD_EN,  1, "idle_read");
    check(16, S_BUSY,   1, "idle_busy");
    check(17, S_WR_EN,  1, "idle_write");
    check(17, S_RD_EN,  0, "idle_rd_off");
    check(18, S_DONE,   1, "idle_done");
    check(18, S_ADDR,   0, "idle_done_addr");
    check(19, S_ADDR,   1, "idle_addr_inc");
    check(19, S_BUSY,   0, "idle_busy_off");
    check(19, S_DONE,   0, "idle_done_off");
    drain();

    // Write traffic from cycle 10 defers the refresh until urgent.
    do_reset();
    for (int k = 10; k <= 18; k++) check(k, S_WR_GNT, 1, "defer_wr_gnt");
    check(18, S_URGENT, 0, "defer_not_urgent");
    check(19, S_URGENT, 1, "defer_urgent");
    check(19, S_WR_GNT, 0, "defer_urgent_gnt");
    check(20, S_RD_EN,  1, "defer_read");
    check(20, S_URGENT, 0, "defer_urgent_off");
    for (int k = 20; k <= 22; k++) check(k, S_WR_GNT, 0, "defer_busy_gnt");
    check(23, S_WR_GNT, 1, "defer_regrant");
    check(23, S_ADDR,   1, "defer_addr_inc");
    go(10);
    wr_req = 1'b1;
    go(24);
    wr_req = 1'b0;
    drain();

    // Simultaneous requests: write wins; read alone is granted.
    do_reset();
    check(2, S_WR_GNT, 1, "prio_wr_gnt");
    check(2, S_RD_GNT, 0, "prio_rd_gnt");
    check(3, S_WR_GNT, 1, "prio_wr_gnt2");
    check(3, S_RD_GNT, 0, "prio_rd_gnt2");
    check(4, S_RD_GNT, 1, "solo_rd_gnt");
    check(4, S_WR_GNT, 0, "solo_wr_gnt");
    go(2);
    wr_req = 1'b1;
    rd_req = 1'b1;
    go(4);
    wr_req = 1'b0;
    go(5);
    rd_req = 1'b0;
    drain();

    // Reads during a refresh are refused, then granted once IDLE.
    do_reset();
    check(16, S_RD_GNT, 0, "busy_rd_read");
    check(17, S_RD_GNT, 0, "busy_rd_write");
    check(18, S_RD_GNT, 0, "busy_rd_done");
    check(19, S_RD_GNT, 1, "busy_rd_after");
    go(16);
    rd_req = 1'b1;
    go(20);
    rd_req = 1'b0;
    drain();

    // Reset in the WRITE cycle aborts the refresh with no done and no increment.
    do_reset();
    check(17, S_WR_EN,   1, "abort_write");
    check(18, S_WR_EN,   0, "abort_wr_en");
    check(18, S_BUSY,    0, "abort_busy");
    check(18, S_DONE,    0, "abort_done");
    check(18, S_ADDR,    0, "abort_addr");
    check(33, S_DONECNT, 0, "abort_no_done");
    check(33, S_ADDR,    0, "abort_addr_hold");
    check(34, S_RD_EN,   1, "abort_reread");
    check(36, S_DONE,    1, "abort_redone");
    check(36, S_ADDR,    0, "abort_redone_addr");
    go(17);
    rst = 1'b1;
    go(18);
    rst = 1'b0;
    drain();

    // Nine idle refreshes: rows 0..7 then wrap to 0, eight done pulses first.
    do_reset();
    for (int r = 0; r <= 8; r++) begin
      check(16 * (r + 1),     S_RD_EN, 1,     "rr_read");
      check(16 * (r + 1),     S_ADDR,  r % 8, "rr_read_addr");
      check(16 * (r + 1) + 2, S_DONE,  1,     "rr_done");
      check(16 * (r + 1) + 2, S_ADDR,  r % 8, "rr_done_addr");
    end
    check(140, S_DONECNT, 8, "rr_done_count");
    check(147, S_ADDR,    1, "rr_wrap_inc");
    check(147, S_DONECNT, 9, "rr_done_count9");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
